// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: combinational decode feeding an
// elastic valid/ready register chain of PIPE_DEPTH stages.
module imm_gen_pipe #(
  parameter int XLEN       = 32,
  parameter int PIPE_DEPTH = 1,
  parameter int TAG_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] T_NONE  = 3'd0;
  localparam logic [2:0] T_I     = 3'd1;
  localparam logic [2:0] T_S     = 3'd2;
  localparam logic [2:0] T_B     = 3'd3;
  localparam logic [2:0] T_U     = 3'd4;
  localparam logic [2:0] T_J     = 3'd5;
  localparam logic [2:0] T_SHAMT = 3'd6;
  localparam logic [2:0] T_ZIMM  = 3'd7;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic            is_shift;
  logic [31:0]     imm32;
  logic            sx;
  logic [XLEN-1:0] d_imm;
  logic [2:0]      d_type;
  logic            d_ill;

  assign opc      = in_instr[6:0];
  assign f3       = in_instr[14:12];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    imm32  = '0;
    sx     = 1'b0;
    d_type = T_NONE;
    d_ill  = 1'b0;
    unique case (opc)
      7'b0010011: begin
        if (is_shift) begin
          d_type = T_SHAMT;
          if (XLEN == 64) begin
            imm32 = {26'b0, in_instr[25:20]};
          end else begin
            imm32 = {27'b0, in_instr[24:20]};
            d_ill = in_instr[25];
          end
        end else begin
          d_type = T_I;
          sx     = 1'b1;
          imm32  = {20'b0, in_instr[31:20]};
        end
      end
      7'b0011011: begin
        if (XLEN != 64) begin
          d_ill = 1'b1;
        end else if (is_shift) begin
          d_type = T_SHAMT;
          imm32  = {27'b0, in_instr[24:20]};
          d_ill  = in_instr[25];
        end else begin
          d_type = T_I;
          sx     = 1'b1;
          imm32  = {20'b0, in_instr[31:20]};
        end
      end
      7'b0000011, 7'b1100111: begin
        d_type = T_I;
        sx     = 1'b1;
        imm32  = {20'b0, in_instr[31:20]};
      end
      7'b0100011: begin
        d_type = T_S;
        sx     = 1'b1;
        imm32  = {20'b0, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        d_type = T_B;
        sx     = 1'b1;
        imm32  = {19'b0, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b1101111: begin
        d_type = T_J;
        sx     = 1'b1;
        imm32  = {11'b0, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        d_type = T_U;
        imm32  = {in_instr[31:12], 12'b0};
        sx     = 1'b1;
      end
      7'b1110011: begin
        if (f3[2]) begin
          d_type = T_ZIMM;
          imm32  = {27'b0, in_instr[19:15]};
        end
      end
      7'b0110011, 7'b0001111: ;
      7'b0111011: d_ill = (XLEN != 64);
      default:    d_ill = 1'b1;
    endcase
  end

  // imm32 holds the raw field right-aligned; extend from its top bit of interest
  always_comb begin
    d_imm = '0;
    if (sx) begin
      unique case (d_type)
        T_S, T_I: d_imm = XLEN'($signed(imm32[11:0]));
        T_B:      d_imm = XLEN'($signed(imm32[12:0]));
        T_J:      d_imm = XLEN'($signed(imm32[20:0]));
        default:  d_imm = XLEN'($signed(imm32));
      endcase
    end else begin
      d_imm = XLEN'(imm32);
    end
  end

  logic [PIPE_DEPTH-1:0]            vld;
  logic [PIPE_DEPTH-1:0][XLEN-1:0]  imm_q;
  logic [PIPE_DEPTH-1:0][2:0]       typ_q;
  logic [PIPE_DEPTH-1:0]            ill_q;
  logic [PIPE_DEPTH-1:0][TAG_W-1:0] tag_q;
  logic [PIPE_DEPTH:0]              rdy;

  always_comb begin
    rdy = '0;
    rdy[PIPE_DEPTH] = out_ready;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      rdy[k] = !vld[k] || rdy[k+1];
    end
  end

  assign in_ready = rdy[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= '0;
      imm_q <= '0;
      typ_q <= '0;
      ill_q <= '0;
      tag_q <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      if (rdy[0]) begin
        vld[0] <= in_valid;
        if (in_valid) begin
          imm_q[0] <= d_imm;
          typ_q[0] <= d_type;
          ill_q[0] <= d_ill;
          tag_q[0] <= in_tag;
        end
      end
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        if (rdy[k]) begin
          vld[k] <= vld[k-1];
          if (vld[k-1]) begin
            imm_q[k] <= imm_q[k-1];
            typ_q[k] <= typ_q[k-1];
            ill_q[k] <= ill_q[k-1];
            tag_q[k] <= tag_q[k-1];
          end
        end
      end
    end
  end

  assign out_valid   = vld[PIPE_DEPTH-1];
  assign out_imm     = imm_q[PIPE_DEPTH-1];
  assign out_type    = typ_q[PIPE_DEPTH-1];
  assign out_illegal = ill_q[PIPE_DEPTH-1];
  assign out_tag     = tag_q[PIPE_DEPTH-1];

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage of the RISC-V core.
- Takes a 32-bit instruction plus an opaque tag (PC or ROB index) through a valid/ready elastic pipeline of PIPE_DEPTH register stages.
- Emits the XLEN-wide sign- or zero-extended immediate, an immediate-type code and an illegal-encoding flag.
- Supports RV32 and RV64 (XLEN), flush, and full backpressure, so decode can stall without losing instructions.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- PIPE_DEPTH, 1, number of register stages, 1..3.
- TAG_W, 32, width of the tag carried alongside each instruction.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of every in-flight entry
- in_valid  input  1  in_instr/in_tag valid
- in_ready  output  1  pipeline accepts an entry this cycle
- in_instr  input  32  raw instruction
- in_tag  input  TAG_W  passthrough tag
- out_valid  output  1  output entry valid
- out_ready  input  1  consumer accepts the output entry
- out_imm  output  XLEN  generated immediate
- out_type  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM
- out_illegal  output  1  unsupported opcode or bad shamt
- out_tag  output  TAG_W  tag of the output entry

Behaviour:
- Reset, asynchronous on rst_n low:
  - every stage valid bit clears.
  - out_valid=0, out_imm=0, out_type=0, out_illegal=0, out_tag=0.
  - in_ready=1 after release.
- Handshake:
  - Transfer occurs on valid&&ready at the clock edge.
  - Stage k holds {valid, imm, type, illegal, tag}.
  - ready_k = !valid_k || ready_(k+1); the last stage uses out_ready.
  - in_ready = ready_0, combinational.
  - A stage may load and unload in the same cycle (full throughput, 1 entry/cycle).
- Latency: PIPE_DEPTH cycles from accepted input to out_valid with no stall.
- Decode is combinational on in_instr before stage 0; later stages only move data.
- Output stability: out_* are driven directly from the last stage and are stable while out_valid && !out_ready.
- Decode rules, by opcode (sign extension copies instr[31] up to bit XLEN-1):
  - 0010011 OP-IMM:
    - funct3 001/101 -> SHAMT, zero-extended. XLEN=32 uses instr[24:20]. XLEN=64 uses instr[25:20].
    - XLEN=32 with instr[25]=1 sets illegal.
    - other funct3 -> I, sext(instr[31:20]).
  - 0011011 OP-IMM-32: legal only when XLEN=64, else illegal/NONE/imm 0.
    - funct3 001/101 -> SHAMT instr[24:20]; instr[25]=1 sets illegal.
    - other funct3 -> I.
  - 0000011 LOAD, 1100111 JALR -> I.
  - 0100011 STORE -> S, sext({instr[31:25],instr[11:7]}).
  - 1100011 BRANCH -> B, sext({instr[31],instr[7],instr[30:25],instr[11:8],0}).
  - 1101111 JAL -> J, sext({instr[31],instr[19:12],instr[20],instr[30:21],0}).
  - 0110111 LUI, 0010111 AUIPC -> U, sext({instr[31:12],12'b0}); upper bits are copies of bit 31 when XLEN=64.
  - 1110011 SYSTEM:
    - funct3 1xx -> ZIMM, zero-extended instr[19:15].
    - else -> NONE, imm 0.
  - 0110011 OP, 0111011 OP-32 (OP-32 legal only when XLEN=64), 0001111 FENCE -> NONE, imm 0.
  - any other opcode -> NONE, imm 0, illegal=1.
- Flush:
  - all valid bits clear on the next edge. The input presented that cycle is dropped even if in_valid&&in_ready.
  - out_valid=0 the following cycle.
  - flush has priority over every handshake.
- Flush and reset both mid-stall: no partial entry survives; tags are not reordered.
- Ordering: strictly FIFO; no entry is duplicated or dropped except by flush.

Test Plan:
- XLEN=32, DEPTH=1: in 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_imm=0xFFFFFFFF, type=1, illegal=0, tag echoed.
- XLEN=32: in 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, type=3. Then 0x01F09093 (slli 31) -> imm=0x1F, type=6. Then 0x03F09093 -> illegal=1.
- XLEN=64: 0x03F09093 -> imm=0x3F, type=6, illegal=0. Then 0x800000B7 (lui) -> imm=0xFFFFFFFF80000000, type=4.
- DEPTH=2, out_ready=0: push tags 1,2,3 -> tags 1,2 accepted; in_ready=0 on tag 3. Raise out_ready -> tags 1,2,3 emerge in order, one per cycle, no gaps.
- DEPTH=3, three entries in flight, flush=1 with in_valid=1 -> next cycle all stages empty, in_ready=1, no out_valid for the flushed or concurrent input.
- 0x0000007F -> type=0, imm=0, illegal=1. Drop rst_n asynchronously mid-stream -> out_valid falls without a clock edge; pipeline is empty after release.
